// File: rtl/mmio_if.sv
// mmio_if: bus bundle between the memory stage and the MMIO peripheral block.
//   addr   - registered byte address from the memory stage
//   din    - write data
//   wr_en  - write strobe
//   mmio   - memory-mapped I/O enable
//   hit    - peripheral claims the access (combinational)
//   dout   - registered read data (one-cycle latency, like the data RAM)
// The master modport is the memory stage side; the slave modport is the peripheral.
interface mmio_if;
  logic [7:0] addr;
  logic [7:0] din;
  logic       wr_en;
  logic       mmio;
  logic       hit;
  logic [7:0] dout;

  modport master (
    output addr,
    output din,
    output wr_en,
    output mmio,
    input  hit,
    input  dout
  );

  modport slave (
    input  addr,
    input  din,
    input  wr_en,
    input  mmio,
    output hit,
    output dout
  );
endinterface

// File: rtl/mmio_io.sv
// mmio_io: memory-mapped I/O block in page 0xF0-0xFF.
//   0xF0 LEDS (rw), 0xF1 TXDATA (wo), 0xF2 STATUS {7'b0, tx_busy} (ro),
//   0xF3 TICK (ro), 0xF4-0xFF reserved (read 0, writes ignored).
// Ports:
//   clk    - clock, all state on rising edge
//   rst_n  - synchronous active-low reset
//   bus    - mmio_if slave modport (addr/din/wr_en/mmio in, hit/dout out)
//   o_leds - LED register
//   o_tx   - UART serial output, idle high, registered
// Build option: define MMIO_TICK_EN to build the prescaler and TICK counter;
// otherwise 0xF3 reads 0 and TICK_DIV is only range-checked.
module mmio_io #(
  parameter int unsigned CLK_HZ   = 12000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned TICK_DIV = 12000
) (
  input  logic       clk,
  input  logic       rst_n,
  mmio_if.slave      bus,
  output logic [7:0] o_leds,
  output logic       o_tx
);

  localparam int unsigned BaudDiv = CLK_HZ / BAUD;
  localparam int unsigned BaudW   = $clog2(BaudDiv);

  if (BaudDiv < 2) begin : g_bad_baud
    $error("mmio_io: CLK_HZ/BAUD must be at least 2");
  end
  if (TICK_DIV < 1) begin : g_bad_tick
    $error("mmio_io: TICK_DIV must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

  logic             hit;
  logic             wr_led;
  logic             wr_tx;
  logic             tx_busy;
  logic [7:0]       tick_val;
  logic [7:0]       rdata;

  logic [7:0]       leds_q, leds_d;
  logic [7:0]       dout_q, dout_d;
  tx_state_e        state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             baud_last;

  assign hit       = bus.mmio & (bus.addr[7:4] == 4'hF);
  assign wr_led    = bus.wr_en & hit & (bus.addr[3:0] == 4'h0);
  assign wr_tx     = bus.wr_en & hit & (bus.addr[3:0] == 4'h1);
  assign tx_busy   = (state_q != StIdle);
  assign baud_last = (baud_q == BaudW'(BaudDiv - 1));

  assign bus.hit  = hit;
  assign bus.dout = dout_q;
  assign o_leds   = leds_q;
  assign o_tx     = tx_q;

`ifdef MMIO_TICK_EN
  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PreW-1:0] pre_q;
  logic [7:0]      tick_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q  <= '0;
      tick_q <= 8'h00;
    end else if (pre_q == PreW'(TICK_DIV - 1)) begin
      pre_q  <= '0;
      tick_q <= tick_q + 8'h01;
    end else begin
      pre_q  <= pre_q + 1'b1;
    end
  end

  assign tick_val = tick_q;
`else
  assign tick_val = 8'h00;
`endif

  // Read mux uses current register values, so a same-cycle write is not yet visible.
  always_comb begin
    rdata = 8'h00;
    case (bus.addr[3:0])
      4'h0:    rdata = leds_q;
      4'h2:    rdata = {7'b0, tx_busy};
      4'h3:    rdata = tick_val;
      default: rdata = 8'h00;
    endcase
  end

  always_comb begin
    dout_d = hit ? rdata : 8'h00;
    leds_d = wr_led ? bus.din : leds_q;
  end

  // TX next state. The line value is derived from the next state so o_tx changes on the
  // same edge as the state, straight from a flop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (wr_tx) begin
          shift_d = bus.din;
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StData;
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StIdle;
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      leds_q  <= 8'h00;
      dout_q  <= 8'h00;
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      leds_q  <= leds_d;
      dout_q  <= dout_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_mmio_io.sv
// tb_mmio_io: directed plus randomized bench for mmio_io with CLK_HZ/BAUD = 4 and
// TICK_DIV = 2. Expected values come from a frame/timeline model: a frame is just its
// start edge and data byte, and every cycle's line level, busy flag and tick count is
// computed arithmetically from edge counts.
module tb_mmio_io;

  localparam int unsigned ClkHz   = 8;
  localparam int unsigned Baud    = 2;
  localparam int unsigned TickDiv = 2;
  localparam int unsigned Bd      = ClkHz / Baud;

  logic clk;
  logic rst_n;
  logic [7:0] o_leds;
  logic o_tx;

  mmio_if bus ();

  mmio_io #(
    .CLK_HZ  (ClkHz),
    .BAUD    (Baud),
    .TICK_DIV(TickDiv)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .o_leds(o_leds),
    .o_tx  (o_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state.
  int         ecount  = 0;  // edges seen
  int         nres    = 0;  // non-reset edges since the last reset
  logic [7:0] leds_m  = 8'h00;
  bit         f_valid = 1'b0;
  int         f_start = 0;  // edge at which the frame's start bit appears
  logic [7:0] f_data  = 8'h00;

  function automatic bit busy_at(input int e);
    return f_valid && (e >= f_start) && (e < f_start + 10 * Bd);
  endfunction

  // Serial line level after edge e: start bit, 8 data bits LSB first, stop bit.
  function automatic logic line_at(input int e);
    int idx;
    if (!busy_at(e)) return 1'b1;
    idx = (e - f_start) / Bd;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return f_data[idx-1];
    return 1'b1;
  endfunction

  function automatic logic [7:0] tick_m();
`ifdef MMIO_TICK_EN
    return 8'((nres / TickDiv) % 256);
`else
    return 8'h00;
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: apply inputs, check hit, clock, then check registered outputs.
  task automatic drive(input logic w, input logic m, input logic [7:0] a, input logic [7:0] d);
    logic       exp_hit;
    logic [7:0] exp_dout;
    bit         acc_led;
    bit         acc_tx;
    bus.wr_en = w;
    bus.mmio  = m;
    bus.addr  = a;
    bus.din   = d;
    #1;
    exp_hit = m && (a[7:4] == 4'hF);
    check("hit", {7'b0, bus.hit}, {7'b0, exp_hit});
    exp_dout = 8'h00;
    if (exp_hit) begin
      if (a == 8'hF0) exp_dout = leds_m;
      else if (a == 8'hF2) exp_dout = {7'b0, busy_at(ecount)};
      else if (a == 8'hF3) exp_dout = tick_m();
    end
    acc_led = w && exp_hit && (a == 8'hF0);
    acc_tx  = w && exp_hit && (a == 8'hF1) && !busy_at(ecount);
    @(posedge clk);
    ecount++;
    nres++;
    if (acc_led) leds_m = d;
    if (acc_tx) begin
      f_valid = 1'b1;
      f_start = ecount;
      f_data  = d;
    end
    @(negedge clk);
    check("dout", bus.dout, exp_dout);
    check("leds", o_leds, leds_m);
    check("tx", {7'b0, o_tx}, {7'b0, line_at(ecount)});
  endtask

  task automatic do_reset(input int n);
    rst_n     = 1'b0;
    bus.wr_en = 1'b0;
    bus.mmio  = 1'b0;
    bus.addr  = 8'h00;
    bus.din   = 8'h00;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      ecount++;
      f_valid = 1'b0;
      leds_m  = 8'h00;
      nres    = 0;
      @(negedge clk);
      check("rst_tx", {7'b0, o_tx}, 8'h01);
      check("rst_leds", o_leds, 8'h00);
      check("rst_dout", bus.dout, 8'h00);
    end
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (busy_at(ecount) && guard < 100) begin
      drive(1'b0, 1'b1, 8'hF2, 8'h00);
      guard++;
    end
    if (guard >= 100) check(tag, 8'h01, 8'h00);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.wr_en = 1'b0;
    bus.mmio  = 1'b0;
    bus.addr  = 8'h00;
    bus.din   = 8'h00;
    @(negedge clk);
    do_reset(3);
    drive(1'b0, 1'b1, 8'hF2, 8'h00);
    check("status_after_reset", bus.dout, 8'h00);

    // LEDS write/readback, then a write with mmio low.
    drive(1'b1, 1'b1, 8'hF0, 8'hA5);
    check("leds_write", o_leds, 8'hA5);
    drive(1'b0, 1'b1, 8'hF0, 8'h00);
    check("leds_read", bus.dout, 8'hA5);
    drive(1'b1, 1'b0, 8'hF0, 8'h5A);
    check("leds_nommio", o_leds, 8'hA5);
    // Write then read in consecutive cycles; same-cycle read sees old value.
    drive(1'b1, 1'b1, 8'hF0, 8'h3C);
    check("leds_same_cycle", bus.dout, 8'hA5);
    drive(1'b0, 1'b1, 8'hF0, 8'h00);
    check("leds_next_cycle", bus.dout, 8'h3C);

    // UART frame 0x55 with a dropped write while busy.
    drive(1'b1, 1'b1, 8'hF1, 8'h55);
    check("start_bit", {7'b0, o_tx}, 8'h00);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 8'hF2, 8'h00);
    check("status_busy", bus.dout, 8'h01);
    drive(1'b1, 1'b1, 8'hF1, 8'hFF);
    wait_idle("frame55_timeout");
    // First idle cycle: back-to-back frame starts immediately.
    drive(1'b1, 1'b1, 8'hF1, 8'h0F);
    check("b2b_start", {7'b0, o_tx}, 8'h00);
    wait_idle("frame0f_timeout");
    drive(1'b0, 1'b1, 8'hF2, 8'h00);
    check("status_idle", bus.dout, 8'h00);

    // Read-only / reserved writes while a frame is running.
    drive(1'b1, 1'b1, 8'hF1, 8'hC3);
    drive(1'b1, 1'b1, 8'hF2, 8'h12);
    drive(1'b1, 1'b1, 8'hF7, 8'h12);
    drive(1'b0, 1'b1, 8'hF2, 8'h00);
    check("status_ro", bus.dout, 8'h01);
    drive(1'b0, 1'b1, 8'hF7, 8'h00);
    check("reserved_read", bus.dout, 8'h00);
    drive(1'b0, 1'b1, 8'hF1, 8'h00);
    check("txdata_read", bus.dout, 8'h00);

    // Reset mid-frame aborts it.
    do_reset(3);
    drive(1'b0, 1'b1, 8'hF2, 8'h00);
    check("status_after_abort", bus.dout, 8'h00);

    // Tick wrap: 514 cycles after reset with TICK_DIV = 2.
    do_reset(1);
    for (int i = 0; i < 514; i++) drive(1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 8'hF3, 8'h00);
`ifdef MMIO_TICK_EN
    check("tick_wrap", bus.dout, 8'h01);
`else
    check("tick_off", bus.dout, 8'h00);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic       w;
      logic       m;
      logic [7:0] a;
      logic [7:0] d;
      w = 1'($urandom_range(0, 1));
      m = ($urandom_range(0, 7) != 0);
      a = ($urandom_range(0, 7) != 0) ? {4'hF, 4'($urandom_range(0, 4))} : 8'($urandom);
      d = 8'($urandom);
      if (a == 8'hF1 && $urandom_range(0, 3) != 0) w = 1'b0;
      drive(w, m, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
